// File: rtl/morra_pkg.sv
// Shared types and the move-dominance helper for the morra cinese controller.
package morra_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_t;

    // Used for both the per-manche result and the match result.
    typedef enum logic [1:0] {
        INV  = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        DRAW = 2'b11
    } res_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    // True when move a defeats move b (sasso>forbice, forbice>carta, carta>sasso).
    function automatic logic beats(input move_t a, input move_t b);
        return ((a == SASSO)   && (b == FORBICE)) ||
               ((a == FORBICE) && (b == CARTA))   ||
               ((a == CARTA)   && (b == SASSO));
    endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational judge for one manche: validity (missing move, banned repeat) and winner.
module morra_judge
    import morra_pkg::*;
(
    input  logic [1:0] primo,
    input  logic [1:0] secondo,
    input  logic       ban_valid,
    input  logic       ban_player,   // 0: primo holds the ban, 1: secondo
    input  logic [1:0] ban_move,
    output res_t       res
);

    // Judge the move pair against the repeat ban and the dominance rule.
    always_comb begin
        res = INV;
        if ((primo == 2'b00) || (secondo == 2'b00)) begin
            res = INV;
        end else if (ban_valid && !ban_player && (primo == ban_move)) begin
            res = INV;
        end else if (ban_valid && ban_player && (secondo == ban_move)) begin
            res = INV;
        end else if (primo == secondo) begin
            res = DRAW;
        end else if (beats(move_t'(primo), move_t'(secondo))) begin
            res = P1;
        end else begin
            res = P2;
        end
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Parametrised morra cinese match controller: config load, per-manche judging, lead/count tracking and end rule.
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int unsigned MAX_BASE   = 4,
    parameter int unsigned MIN_MANCHE = 4,
    parameter int unsigned LEAD_WIN   = 2,
    parameter int unsigned BAN_REPEAT = 1,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned LEAD_W     = CNT_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               primo,
    input  logic [1:0]               secondo,
    input  logic                     inizia,
    output logic [1:0]               manche,
    output logic [1:0]               partita,
    output logic signed [LEAD_W-1:0] vantaggio,
    output logic [CNT_W-1:0]         n_manche
);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           max_q, max_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [LEAD_W-1:0]   lead_q, lead_d;
    logic                       ban_valid_q, ban_valid_d;
    logic                       ban_player_q, ban_player_d;
    logic [1:0]                 ban_move_q, ban_move_d;
    res_t                       manche_q, manche_d;
    res_t                       partita_q, partita_d;
    logic [LEAD_W-1:0]          lead_abs;
    res_t                       judge_res;
    logic                       ban_en;

    assign ban_en = ban_valid_q && (BAN_REPEAT != 0);

    morra_judge u_judge (
        .primo      (primo),
        .secondo    (secondo),
        .ban_valid  (ban_en),
        .ban_player (ban_player_q),
        .ban_move   (ban_move_q),
        .res        (judge_res)
    );

    // Next-state: restart on inizia, otherwise judge one manche per clock while in PLAY.
    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        cnt_d        = cnt_q;
        lead_d       = lead_q;
        ban_valid_d  = ban_valid_q;
        ban_player_d = ban_player_q;
        ban_move_d   = ban_move_q;
        manche_d     = INV;
        partita_d    = partita_q;
        lead_abs     = '0;

        if (inizia) begin
            max_d       = CNT_W'({primo, secondo}) + CNT_W'(MAX_BASE);
            cnt_d       = '0;
            lead_d      = '0;
            ban_valid_d = 1'b0;
            partita_d   = INV;
            state_d     = PLAY;
        end else if ((state_q == PLAY) && (judge_res != INV)) begin
            cnt_d    = cnt_q + CNT_W'(1);
            manche_d = judge_res;
            unique case (judge_res)
                P1: begin
                    lead_d       = lead_q + LEAD_W'(1);
                    ban_valid_d  = 1'b1;
                    ban_player_d = 1'b0;
                    ban_move_d   = primo;
                end
                P2: begin
                    lead_d       = lead_q - LEAD_W'(1);
                    ban_valid_d  = 1'b1;
                    ban_player_d = 1'b1;
                    ban_move_d   = secondo;
                end
                default: ban_valid_d = 1'b0;
            endcase

            lead_abs = lead_d[LEAD_W-1] ? LEAD_W'(-lead_d) : LEAD_W'(lead_d);

            // End rule on the post-update count and lead; both conditions share the same verdict.
            if ((cnt_d == max_q) ||
                ((cnt_d >= CNT_W'(MIN_MANCHE)) && (lead_abs >= LEAD_W'(LEAD_WIN)))) begin
                state_d = DONE;
                if (lead_d == '0)          partita_d = DRAW;
                else if (lead_d[LEAD_W-1]) partita_d = P2;
                else                       partita_d = P1;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            max_q        <= '0;
            cnt_q        <= '0;
            lead_q       <= '0;
            ban_valid_q  <= 1'b0;
            ban_player_q <= 1'b0;
            ban_move_q   <= 2'b00;
            manche_q     <= INV;
            partita_q    <= INV;
        end else begin
            state_q      <= state_d;
            max_q        <= max_d;
            cnt_q        <= cnt_d;
            lead_q       <= lead_d;
            ban_valid_q  <= ban_valid_d;
            ban_player_q <= ban_player_d;
            ban_move_q   <= ban_move_d;
            manche_q     <= manche_d;
            partita_q    <= partita_d;
        end
    end

    assign manche    = manche_q;
    assign partita   = partita_q;
    assign vantaggio = lead_q;
    assign n_manche  = cnt_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Scoreboard bench: the driver queues the expected post-edge outputs, a monitor pops and compares after each edge.
module tb_morra_cinese_param;

    logic              clk;
    logic              rst;
    logic [1:0]        primo, secondo;
    logic              inizia;
    logic [1:0]        manche_a, partita_a, manche_b, partita_b;
    logic signed [5:0] vant_a, vant_b;
    logic [4:0]        n_a, n_b;

    typedef struct {
        bit                sel;     // 0: ban-enabled DUT, 1: ban-disabled DUT
        logic [1:0]        m;
        logic [1:0]        p;
        logic signed [5:0] v;
        logic [4:0]        n;
        string             name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    morra_cinese_param dut (
        .clk(clk), .rst(rst), .primo(primo), .secondo(secondo), .inizia(inizia),
        .manche(manche_a), .partita(partita_a), .vantaggio(vant_a), .n_manche(n_a)
    );

    morra_cinese_param #(.BAN_REPEAT(0)) dut_nb (
        .clk(clk), .rst(rst), .primo(primo), .secondo(secondo), .inizia(inizia),
        .manche(manche_b), .partita(partita_b), .vantaggio(vant_b), .n_manche(n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one queued expectation is consumed per clock edge that the driver armed.
    initial begin
        exp_t              e;
        logic [1:0]        am, ap;
        logic signed [5:0] av;
        logic [4:0]        an;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                am = e.sel ? manche_b  : manche_a;
                ap = e.sel ? partita_b : partita_a;
                av = e.sel ? vant_b    : vant_a;
                an = e.sel ? n_b       : n_a;
                checks++;
                if (am !== e.m || ap !== e.p || av !== e.v || an !== e.n) begin
                    errors++;
                    $display("FAIL %s: got manche=%b partita=%b vantaggio=%0d n_manche=%0d, want manche=%b partita=%b vantaggio=%0d n_manche=%0d",
                             e.name, am, ap, av, an, e.m, e.p, e.v, e.n);
                end
            end
        end
    end

    task automatic step(input logic [1:0] p, input logic [1:0] s, input logic ini,
                        input logic [1:0] em, input logic [1:0] ep, input int ev, input int en,
                        input bit sel, input string nm);
        exp_t e;
        @(negedge clk);
        primo   = p;
        secondo = s;
        inizia  = ini;
        e.sel  = sel;
        e.m    = em;
        e.p    = ep;
        e.v    = 6'(ev);
        e.n    = 5'(en);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; primo = 2'b00; secondo = 2'b00; inizia = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        step(2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, "reset_idle");

        // Test 1: max 6, ban blocks secondo repeating carta, ends in a draw.
        step(2'b00, 2'b10, 1, 2'b00, 2'b00,  0, 0, 0, "t1_start");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00, -1, 1, 0, "t1_m1");
        step(2'b11, 2'b10, 0, 2'b00, 2'b00, -1, 1, 0, "t1_ban");
        step(2'b01, 2'b11, 0, 2'b01, 2'b00,  0, 2, 0, "t1_m3");
        step(2'b11, 2'b11, 0, 2'b11, 2'b00,  0, 3, 0, "t1_m4");
        step(2'b11, 2'b10, 0, 2'b01, 2'b00,  1, 4, 0, "t1_m5");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00,  0, 5, 0, "t1_m6");
        step(2'b11, 2'b11, 0, 2'b11, 2'b11,  0, 6, 0, "t1_end");
        step(2'b01, 2'b10, 0, 2'b00, 2'b11,  0, 6, 0, "t1_done_hold");

        // Test 2: max 5, secondo wins on the max count.
        step(2'b00, 2'b01, 1, 2'b00, 2'b00,  0, 0, 0, "t2_start");
        step(2'b01, 2'b11, 0, 2'b01, 2'b00,  1, 1, 0, "t2_m1");
        step(2'b10, 2'b01, 0, 2'b01, 2'b00,  2, 2, 0, "t2_m2");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00,  1, 3, 0, "t2_m3");
        step(2'b10, 2'b11, 0, 2'b10, 2'b00,  0, 4, 0, "t2_m4");
        step(2'b11, 2'b01, 0, 2'b10, 2'b10, -1, 5, 0, "t2_end");

        // Test 3: max 19, lead 3 below MIN_MANCHE, primo ban, early win at count 4.
        step(2'b11, 2'b11, 1, 2'b00, 2'b00,  0, 0, 0, "t3_start");
        step(2'b01, 2'b11, 0, 2'b01, 2'b00,  1, 1, 0, "t3_m1");
        step(2'b10, 2'b01, 0, 2'b01, 2'b00,  2, 2, 0, "t3_m2");
        step(2'b11, 2'b10, 0, 2'b01, 2'b00,  3, 3, 0, "t3_m3_lead3");
        step(2'b11, 2'b01, 0, 2'b00, 2'b00,  3, 3, 0, "t3_ban");
        step(2'b01, 2'b10, 0, 2'b10, 2'b01,  2, 4, 0, "t3_early_win");

        // Test 4: asynchronous reset between edges, then moves ignored in IDLE.
        step(2'b00, 2'b00, 1, 2'b00, 2'b00,  0, 0, 0, "t4_start");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00, -1, 1, 0, "t4_m1");
        @(negedge clk);
        primo = 2'b00; secondo = 2'b00; inizia = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (manche_a !== 2'b00 || partita_a !== 2'b00 || vant_a !== 6'sd0 || n_a !== 5'd0) begin
            errors++;
            $display("FAIL t4_async_reset: got manche=%b partita=%b vantaggio=%0d n_manche=%0d, want all 0",
                     manche_a, partita_a, vant_a, n_a);
        end
        @(negedge clk);
        rst = 1'b0;
        step(2'b01, 2'b10, 0, 2'b00, 2'b00,  0, 0, 0, "t4_idle_ignore");

        // Test 5: mid-match restart clears state and loads a shorter max, then DONE holds.
        step(2'b00, 2'b11, 1, 2'b00, 2'b00,  0, 0, 0, "t5_start_max7");
        step(2'b01, 2'b11, 0, 2'b01, 2'b00,  1, 1, 0, "t5_m1");
        step(2'b10, 2'b01, 0, 2'b01, 2'b00,  2, 2, 0, "t5_m2");
        step(2'b00, 2'b00, 1, 2'b00, 2'b00,  0, 0, 0, "t5_restart_max4");
        step(2'b01, 2'b01, 0, 2'b11, 2'b00,  0, 1, 0, "t5_d1");
        step(2'b10, 2'b10, 0, 2'b11, 2'b00,  0, 2, 0, "t5_d2");
        step(2'b11, 2'b11, 0, 2'b11, 2'b00,  0, 3, 0, "t5_d3");
        step(2'b01, 2'b01, 0, 2'b11, 2'b11,  0, 4, 0, "t5_max_end");
        step(2'b01, 2'b10, 0, 2'b00, 2'b11,  0, 4, 0, "t5_done_hold");

        // Test 6: ban disabled, secondo may repeat its winning move.
        step(2'b00, 2'b10, 1, 2'b00, 2'b00,  0, 0, 1, "t6_start");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00, -1, 1, 1, "t6_m1");
        step(2'b01, 2'b10, 0, 2'b10, 2'b00, -2, 2, 1, "t6_repeat");

        @(negedge clk);
        primo = 2'b00; secondo = 2'b00; inizia = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
